// File: rtl/cartridge_loader.sv
// cartridge_loader: consumes a framed host byte stream and loads it into the
// cartridge CROM array over Wishbone, then programs the cartridge control register.
`default_nettype none

module cartridge_loader #(
    parameter int unsigned ARRAY_SIZE = 17409,
    parameter int unsigned TIMEOUT    = 1048575
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [0:7]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [0:1]  err_code,
    output logic [0:20] wb_adr_o,
    output logic [0:7]  wb_dat_o,
    output logic        wb_we_o,
    output logic [0:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_C    = CW'(TIMEOUT);
    localparam logic [16:0]   LIMIT_C = 17'(ARRAY_SIZE);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HDR       = 3'd1;
    localparam logic [2:0] S_QUIESCE   = 3'd2;
    localparam logic [2:0] S_DATA_WAIT = 3'd3;
    localparam logic [2:0] S_DATA_WR   = 3'd4;
    localparam logic [2:0] S_CSUM      = 3'd5;
    localparam logic [2:0] S_CTRL_WR   = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [7:0]    ctrl_q, ctrl_d, data_q, data_d, sum_q, sum_d;
    logic [15:0]   len_q, len_d, adr_q, adr_d, cnt_q, cnt_d;
    logic [14:0]   ptr_q, ptr_d;
    logic [1:0]    hidx_q, hidx_d, errc_q, errc_d;
    logic [CW-1:0] idle_q, idle_d;
    logic          pend_q, pend_d, stb_q, stb_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;

    logic [7:0]  w_byte, w_sum;
    logic        w_acc, w_wait, w_timeout, w_fail;
    logic [1:0]  w_fail_code;
    logic [16:0] w_end;

    assign w_byte = s_data;
    assign w_sum  = sum_q + w_byte;
    assign w_wait = (state_q == S_HDR) || (state_q == S_DATA_WAIT) || (state_q == S_CSUM);
    assign s_ready = reset_n && !abort && (w_wait || (state_q == S_IDLE));
    assign w_acc  = s_valid && s_ready;
    assign w_end  = {1'b0, adr_q[15:8], w_byte} + {1'b0, len_q};
    // The idle counter keeps running through writes, so a slow slave eats into the budget.
    assign w_timeout = (TIMEOUT != 0) && w_wait && !w_acc &&
                       (({1'b0, idle_q} + 1'b1) >= {1'b0, TO_C});

    always_comb begin
        state_d = state_q;  ctrl_d = ctrl_q;  data_d = data_q;  sum_d = sum_q;
        len_d   = len_q;    adr_d  = adr_q;   cnt_d  = cnt_q;   ptr_d = ptr_q;
        hidx_d  = hidx_q;   errc_d = errc_q;  pend_d = pend_q;  stb_d = stb_q;
        busy_d  = busy_q;   error_d = error_q; done_d = 1'b0;
        w_fail  = 1'b0;     w_fail_code = 2'b00;
        idle_d  = idle_q;

        if (state_q == S_IDLE || w_acc) begin
            idle_d = '0;
        end else if (idle_q != TO_C) begin
            idle_d = idle_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_acc) begin
                    ctrl_d  = w_byte;
                    sum_d   = w_byte;
                    error_d = 1'b0;
                    errc_d  = 2'b00;
                    busy_d  = 1'b1;
                    hidx_d  = 2'd0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (abort || w_timeout) begin
                    w_fail = 1'b1;  w_fail_code = 2'b11;
                end else if (w_acc) begin
                    sum_d  = w_sum;
                    hidx_d = hidx_q + 2'd1;
                    case (hidx_q)
                        2'd0:    len_d[15:8] = w_byte;
                        2'd1:    len_d[7:0]  = w_byte;
                        2'd2:    adr_d[15:8] = w_byte;
                        default: adr_d[7:0]  = w_byte;
                    endcase
                    if (hidx_q == 2'd3) begin
                        if (w_end > LIMIT_C) begin
                            w_fail = 1'b1;  w_fail_code = 2'b01;
                        end else begin
                            state_d = S_QUIESCE;
                            stb_d   = 1'b1;
                            pend_d  = 1'b0;
                        end
                    end
                end
            end
            S_QUIESCE: begin
                if (abort) pend_d = 1'b1;
                if (wb_ack_i) begin
                    stb_d = 1'b0;
                    if (pend_q || abort) begin
                        w_fail = 1'b1;  w_fail_code = 2'b11;
                    end else if (len_q == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        ptr_d   = adr_q[14:0];
                        cnt_d   = len_q;
                        state_d = S_DATA_WAIT;
                    end
                end
            end
            S_DATA_WAIT: begin
                if (abort || w_timeout) begin
                    w_fail = 1'b1;  w_fail_code = 2'b11;
                end else if (w_acc) begin
                    data_d  = w_byte;
                    sum_d   = w_sum;
                    stb_d   = 1'b1;
                    state_d = S_DATA_WR;
                end
            end
            S_DATA_WR: begin
                if (abort) pend_d = 1'b1;
                if (wb_ack_i) begin
                    stb_d = 1'b0;
                    ptr_d = ptr_q + 15'd1;
                    cnt_d = cnt_q - 16'd1;
                    if (pend_q || abort) begin
                        w_fail = 1'b1;  w_fail_code = 2'b11;
                    end else begin
                        state_d = (cnt_q == 16'd1) ? S_CSUM : S_DATA_WAIT;
                    end
                end
            end
            S_CSUM: begin
                if (abort || w_timeout) begin
                    w_fail = 1'b1;  w_fail_code = 2'b11;
                end else if (w_acc) begin
                    sum_d = w_sum;
                    if (w_sum != 8'h00) begin
                        w_fail = 1'b1;  w_fail_code = 2'b10;
                    end else begin
                        stb_d   = 1'b1;
                        state_d = S_CTRL_WR;
                    end
                end
            end
            S_CTRL_WR: begin
                if (abort) pend_d = 1'b1;
                if (wb_ack_i) begin
                    stb_d = 1'b0;
                    if (pend_q || abort) begin
                        w_fail = 1'b1;  w_fail_code = 2'b11;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_fail) begin
            state_d = S_IDLE;
            error_d = 1'b1;
            errc_d  = w_fail_code;
            busy_d  = 1'b0;
            stb_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;  ctrl_q <= '0;  data_q <= '0;  sum_q <= '0;
            len_q   <= '0;      adr_q  <= '0;  cnt_q  <= '0;  ptr_q <= '0;
            hidx_q  <= '0;      errc_q <= '0;  idle_q <= '0;  pend_q <= 1'b0;
            stb_q   <= 1'b0;    busy_q <= 1'b0; done_q <= 1'b0; error_q <= 1'b0;
        end else begin
            state_q <= state_d; ctrl_q <= ctrl_d; data_q <= data_d; sum_q <= sum_d;
            len_q   <= len_d;   adr_q  <= adr_d;  cnt_q  <= cnt_d;  ptr_q <= ptr_d;
            hidx_q  <= hidx_d;  errc_q <= errc_d; idle_q <= idle_d; pend_q <= pend_d;
            stb_q   <= stb_d;   busy_q <= busy_d; done_q <= done_d; error_q <= error_d;
        end
    end

    // Bus fields are gated by the strobe so an idle or reset bus reads all-zero.
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = stb_q;
    assign wb_we_o  = stb_q;
    assign wb_sel_o = stb_q;
    assign wb_adr_o = (stb_q && state_q == S_DATA_WR) ? {1'b1, 5'b00000, ptr_q} : 21'd0;
    assign wb_dat_o = !stb_q                  ? 8'h00  :
                      (state_q == S_DATA_WR)  ? data_q :
                      (state_q == S_CTRL_WR)  ? ctrl_q : 8'h00;

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = errc_q;

endmodule

`default_nettype wire

// File: tb/tb_cartridge_loader.sv
// tb_cartridge_loader: directed self-checking bench for cartridge_loader.
`default_nettype none

module tb_cartridge_loader;

    logic        clk;
    logic        reset_n;
    logic [0:7]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic [0:1]  err_code;
    logic [0:20] wb_adr_o;
    logic [0:7]  wb_dat_o;
    logic        wb_we_o;
    logic [0:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;

    cartridge_loader #(.ARRAY_SIZE(17409), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .abort(abort),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0, n_err = 0;
    int done_cnt = 0, stb_seen = 0, stab_err = 0, gap_err = 0, wr_idx = 0;
    int ack_delay = 0, drop_idx = -1;
    logic [7:0]  tb_sum;
    logic [20:0] log_adr[$];
    logic [7:0]  log_dat[$];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wb_stb_o) stb_seen++;
    end

    // Wishbone slave: programmable ack latency, logs each acknowledged write.
    initial begin : slave
        int scnt;
        int cur;
        logic [20:0] h_adr;
        logic [7:0]  h_dat;
        scnt = 0;
        wb_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            cur = (wr_idx == drop_idx) ? ack_delay + 4 : ack_delay;
            if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                if (wb_stb_o) gap_err++;
                scnt = 0;
            end else if (wb_stb_o) begin
                if (scnt == 0) begin
                    h_adr = wb_adr_o;
                    h_dat = wb_dat_o;
                end else if (wb_adr_o !== h_adr || wb_dat_o !== h_dat) begin
                    stab_err++;
                end
                if (scnt >= cur) begin
                    wb_ack_i = 1'b1;
                    log_adr.push_back(wb_adr_o);
                    log_dat.push_back(wb_dat_o);
                    wr_idx++;
                end else begin
                    scnt++;
                end
            end else begin
                scnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        log_adr.delete();
        log_dat.delete();
        done_cnt = 0; stb_seen = 0; stab_err = 0; gap_err = 0; wr_idx = 0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_bound", 32'(n < 200), 32'd1);
        @(posedge clk);
        tb_sum = tb_sum + b;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic header(input logic [7:0] c, input logic [15:0] len, input logic [15:0] adr);
        tb_sum = 8'h00;
        send(c);
        send(len[15:8]);
        send(len[7:0]);
        send(adr[15:8]);
        send(adr[7:0]);
    endtask

    task automatic csum(input logic [7:0] adj);
        logic [7:0] c;
        c = (8'h00 - tb_sum) + adj;
        send(c);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || wb_cyc_o) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 400), 32'd1);
        @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [20:0] a, input logic [7:0] d);
        logic [20:0] ga;
        logic [7:0]  gd;
        ga = (i < log_adr.size()) ? log_adr[i] : 21'h1fffff;
        gd = (i < log_dat.size()) ? log_dat[i] : 8'hxx;
        chk({tag, "_adr"}, 32'(ga), 32'(a));
        chk({tag, "_dat"}, 32'(gd), 32'(d));
    endtask

    initial begin : stim
        reset_n = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        abort   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_wb", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'd0);
        chk("rst_wb_adr", 32'(wb_adr_o), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", 32'(s_ready), 32'd1);

        // Basic three-byte load at 0x0010.
        clear_stats();
        header(8'h81, 16'h0003, 16'h0010);
        send(8'hAA); send(8'hBB); send(8'hCC);
        csum(8'h00);
        wait_idle("t1_idle");
        chk("t1_nwr", 32'(log_adr.size()), 32'd5);
        chk_wr("t1_q", 0, 21'h000000, 8'h00);
        chk_wr("t1_w0", 1, 21'h100010, 8'hAA);
        chk_wr("t1_w1", 2, 21'h100011, 8'hBB);
        chk_wr("t1_w2", 3, 21'h100012, 8'hCC);
        chk_wr("t1_c", 4, 21'h000000, 8'h81);
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_error", 32'(error), 32'd0);

        // Load ending exactly at ARRAY_SIZE.
        clear_stats();
        header(8'h05, 16'h0002, 16'h43FF);
        send(8'h11); send(8'h22);
        csum(8'h00);
        wait_idle("t2_idle");
        chk("t2_nwr", 32'(log_adr.size()), 32'd4);
        chk_wr("t2_w0", 1, 21'h1043FF, 8'h11);
        chk_wr("t2_w1", 2, 21'h104400, 8'h22);
        chk_wr("t2_c", 3, 21'h000000, 8'h05);
        chk("t2_done", 32'(done_cnt), 32'd1);

        // One byte past the end: range error, bus untouched.
        clear_stats();
        header(8'h05, 16'h0002, 16'h4400);
        wait_idle("t2b_idle");
        chk("t2b_error", 32'(error), 32'd1);
        chk("t2b_err_code", 32'(err_code), 32'd1);
        chk("t2b_stb", 32'(stb_seen), 32'd0);
        chk("t2b_busy", 32'(busy), 32'd0);

        // Slow slave with an extra-long ack on the third data write.
        clear_stats();
        ack_delay = 5;
        drop_idx  = 3;
        header(8'h02, 16'h0004, 16'h0100);
        chk("t3_err_clr", 32'(error), 32'd0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        csum(8'h00);
        wait_idle("t3_idle");
        ack_delay = 0;
        drop_idx  = -1;
        chk("t3_nwr", 32'(log_adr.size()), 32'd6);
        chk_wr("t3_w0", 1, 21'h100100, 8'h01);
        chk_wr("t3_w2", 3, 21'h100102, 8'h03);
        chk_wr("t3_w3", 4, 21'h100103, 8'h04);
        chk_wr("t3_c", 5, 21'h000000, 8'h02);
        chk("t3_stable", 32'(stab_err), 32'd0);
        chk("t3_gap", 32'(gap_err), 32'd0);
        chk("t3_done", 32'(done_cnt), 32'd1);

        // Checksum off by one.
        clear_stats();
        header(8'h33, 16'h0001, 16'h0020);
        send(8'h5A);
        csum(8'h01);
        wait_idle("t4_idle");
        chk("t4_nwr", 32'(log_adr.size()), 32'd2);
        chk_wr("t4_w0", 1, 21'h100020, 8'h5A);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_err_code", 32'(err_code), 32'd2);
        chk("t4_done", 32'(done_cnt), 32'd0);

        // Stall after two of four data bytes: timeout 16 cycles after the last byte.
        clear_stats();
        header(8'h44, 16'h0004, 16'h0200);
        send(8'h10); send(8'h20);
        repeat (15) @(negedge clk);
        chk("t5_before", 32'(error), 32'd0);
        @(negedge clk);
        chk("t5_error", 32'(error), 32'd1);
        chk("t5_err_code", 32'(err_code), 32'd3);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_nwr", 32'(log_adr.size()), 32'd3);
        clear_stats();
        header(8'h81, 16'h0003, 16'h0010);
        send(8'hAA); send(8'hBB); send(8'hCC);
        csum(8'h00);
        wait_idle("t5b_idle");
        chk("t5b_done", 32'(done_cnt), 32'd1);
        chk("t5b_error", 32'(error), 32'd0);
        chk("t5b_err_code", 32'(err_code), 32'd0);

        // Abort while a data write is outstanding.
        clear_stats();
        ack_delay = 8;
        header(8'h77, 16'h0002, 16'h0300);
        send(8'h9C);
        abort = 1'b1;
        chk("t6_stb_held", 32'(wb_stb_o), 32'd1);
        @(negedge clk);
        chk("t6_adr_held", 32'(wb_adr_o), 32'h100300);
        @(negedge clk);
        abort = 1'b0;
        wait_idle("t6_idle");
        ack_delay = 0;
        chk("t6_nwr", 32'(log_adr.size()), 32'd2);
        chk_wr("t6_w0", 1, 21'h100300, 8'h9C);
        chk("t6_error", 32'(error), 32'd1);
        chk("t6_err_code", 32'(err_code), 32'd3);
        chk("t6_done", 32'(done_cnt), 32'd0);

        // Asynchronous reset in the middle of a data write.
        clear_stats();
        header(8'h10, 16'h0001, 16'h0400);
        ack_delay = 1000;
        send(8'h66);
        chk("t7_stb_pre", 32'(wb_stb_o), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t7_wb", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'd0);
        chk("t7_wb_adr", 32'(wb_adr_o), 32'd0);
        chk("t7_wb_dat", 32'(wb_dat_o), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ack_delay = 0;
        @(negedge clk);
        chk("t7_idle_ready", 32'(s_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cartridge_loader.md
Name: cartridge_loader

Overview:
- Upstream wishbone master for the cartridge ROM store's CROM access port.
- Consumes a byte stream from the host bridge: header, image bytes, checksum.
- Writes the image bytes into the CROM array, then programs the cartridge control register (banked/mm/mbx/bank).
- Quiesces cartridge banking before loading and reports done/error status to the host.

Parameters:
- ARRAY_SIZE, 17409, number of CROM bytes; highest legal address is ARRAY_SIZE-1.
- TIMEOUT, 1048575, idle cycles allowed between stream bytes mid-load before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_data  in  [0:7]  stream byte, bit 0 = MSB
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader accepts s_data this cycle
- abort  in  1  host abort request, level sampled
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky error flag, cleared when the next load starts
- err_code  out  [0:1]  00 none, 01 range, 10 checksum, 11 abort/timeout
- wb_adr_o  out  [0:20]  bit 0 = 1 array, 0 control; bits 1:5 = 0; bits 6:20 = array address
- wb_dat_o  out  [0:7]  write data
- wb_we_o  out  1  always 1 while wb_cyc_o
- wb_sel_o  out  [0:0]  always 1 while wb_cyc_o
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  slave acknowledge

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0 (s_ready 0, busy 0, done 0, error 0, err_code 00, all wb_* 0); checksum, counters and latched header cleared. Reset mid-transfer drops stb/cyc immediately; no completion is attempted.
- Stream frame: CTRL, LEN_HI, LEN_LO, ADR_HI, ADR_LO, LEN data bytes, CSUM. LEN and ADR are 16-bit big-endian.
- Byte transfer occurs on a cycle where s_valid && s_ready.
- s_ready is 1 only in states IDLE, HDR, DATA_WAIT and CSUM, and only when abort=0.
- Checksum: 8-bit sum mod 256 of every frame byte from CTRL through CSUM inclusive. The frame passes when the sum is 0x00.
- State IDLE:
  - First accepted byte latches CTRL, seeds the checksum, clears error/err_code, sets busy, and moves to HDR.
- State HDR:
  - Accept 4 bytes.
  - After ADR_LO, check ADR+LEN <= ARRAY_SIZE using 17-bit arithmetic.
  - Fail: error=1, err_code=01, return to IDLE with no bus activity.
  - Pass: go to QUIESCE.
- State QUIESCE: control write, adr bit0=0, dat 0x00. This disables mm/mbx/banked and forces bank to 00 while loading.
- Wishbone write rule, used for every write:
  - Assert cyc/stb/we/sel together and hold adr/dat stable until wb_ack_i=1.
  - Deassert cyc/stb in the cycle after ack is sampled.
  - Hold stb/cyc low for at least one cycle before the next strobe.
  - Never re-issue on the same ack.
  - Unbounded ack wait, because the slave may drop ack when a CPU access collides.
- After QUIESCE: LEN=0 goes to CSUM; otherwise go to DATA_WAIT with pointer = ADR[1:15] and count = LEN.
- State DATA_WAIT: accept one byte, add it to the checksum, go to DATA_WR.
- State DATA_WR:
  - Write the byte to array address = pointer (adr bit0=1, bits 6:20 = pointer).
  - On ack: pointer+1 and count-1.
  - count reaches 0 goes to CSUM; otherwise back to DATA_WAIT.
  - The pointer never wraps; the range check already guaranteed this.
- State CSUM: accept one byte.
  - Sum nonzero: error=1, err_code=10, go to IDLE. The control register stays at 0x00 and the array keeps the written data.
  - Sum zero: go to CTRL_WR.
- State CTRL_WR: control write with dat = CTRL. On ack, done pulses for one cycle, busy=0, go to IDLE.
- Timeout:
  - Applies in HDR, DATA_WAIT and CSUM.
  - An idle counter increments on each cycle with no accepted byte and resets on every accepted byte.
  - Reaching TIMEOUT gives err_code=11, error=1, and a return to IDLE.
- Abort:
  - In a waiting state: err_code=11, error=1, go to IDLE the next cycle.
  - During an outstanding wishbone write: finish that write (wait for ack), then go to IDLE with err_code=11. CTRL_WR is included, in which case done does not pulse.
- Simultaneous abort and s_valid: abort wins, because s_ready=0 that cycle.
- busy: 1 from the first accepted byte until return to IDLE.

Test Plan:
- Frame 81,00,03,00,10,AA,BB,CC,CSUM=(-sum)&FF:
  - Control write 00 first.
  - Array writes 0x0010=AA, 0x0011=BB, 0x0012=CC.
  - Control write 81.
  - done pulses once; error stays 0.
- LEN=0002, ADR=0x43FF, i.e. end 17409, exactly at the limit: writes to 0x43FF and 0x4400 complete. Same frame with ADR=0x4400: error, err_code=01, no wishbone strobe at all.
- Slave holds ack low for 5 cycles and inserts a dropped ack on the third data write: adr/dat stay stable, each byte is written exactly once, and stb shows a ≥1-cycle low gap between writes.
- Checksum off by one: data written, no control write after the 00 quiesce, err_code=10, done stays 0.
- TIMEOUT=16 with the stream stalled after 2 of 4 data bytes: error asserts 16 cycles after the last accepted byte, err_code=11, then a fresh valid frame succeeds and clears error.
- Assert abort while a DATA_WR stb is pending: the write completes on ack, then IDLE with err_code=11. Separately, reset_n low mid-DATA_WR: all wb_* go to 0 asynchronously and busy=0.
